// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - round-robin multi-master AHB arbiter
// Registered one-hot grant plus address/data-phase owner pipeline; bursts and locked sequences are never broken.
module ahb_master_arbiter #(
  parameter int MST_NUM    = 3,
  parameter int DEF_MASTER = 0,
  localparam int MW        = $clog2(MST_NUM)
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [MST_NUM-1:0] hbusreq,
  input  logic [MST_NUM-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hburst,
  input  logic               hready,
  output logic [MST_NUM-1:0] hgrant,
  output logic [MW-1:0]      hmaster,
  output logic [MW-1:0]      hmaster_data,
  output logic               hmastlock
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_INCR   = 3'b001;

  localparam logic [MST_NUM-1:0] ONE       = {{(MST_NUM-1){1'b0}}, 1'b1};
  localparam logic [MST_NUM-1:0] DEF_GRANT = ONE << DEF_MASTER;
  localparam logic [MW-1:0]      DEF_IDX   = MW'(DEF_MASTER);

  logic [3:0]    cnt;
  logic [MW-1:0] rr;
  logic [MW-1:0] grant_idx;
  logic [MW-1:0] win_idx;
  logic          win_found;
  logic [4:0]    burst_len;
  logic          last_beat;
  logic          lock_hold;
  logic          arb_en;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (hgrant[i]) grant_idx = MW'(i);
    end
  end

  // burst_len of 0 marks undefined-length INCR
  always_comb begin
    burst_len = 5'd1;
    case (hburst[2:1])
      2'b00:   burst_len = hburst[0] ? 5'd0 : 5'd1;
      2'b01:   burst_len = 5'd4;
      2'b10:   burst_len = 5'd8;
      default: burst_len = 5'd16;
    endcase
  end

  always_comb begin
    last_beat = 1'b0;
    case (htrans)
      T_IDLE:   last_beat = 1'b1;
      T_NONSEQ: last_beat = (burst_len == 5'd1);
      T_SEQ:    last_beat = (cnt == 4'd1);
      default:  last_beat = 1'b0;
    endcase
    if ((htrans == T_NONSEQ || htrans == T_SEQ) && hburst == B_INCR && !hbusreq[hmaster])
      last_beat = 1'b1;
  end

  assign lock_hold = hlock[grant_idx];
  assign arb_en    = hready & last_beat & ~lock_hold;

  // Walk offsets from the far end so the nearest requester after rr wins; rr itself is offset MST_NUM
  always_comb begin
    int c;
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    for (int i = MST_NUM; i >= 1; i--) begin
      c = (int'(rr) + i) % MST_NUM;
      if (hbusreq[c[MW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = c[MW-1:0];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant       <= DEF_GRANT;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      hmastlock    <= 1'b0;
      cnt          <= 4'd0;
      rr           <= DEF_IDX;
    end else if (hready) begin
      hmaster_data <= hmaster;
      hmaster      <= grant_idx;
      hmastlock    <= hlock[grant_idx];
      case (htrans)
        T_NONSEQ: cnt <= (burst_len == 5'd0) ? 4'd0 : 4'(burst_len - 5'd1);
        T_SEQ:    if (cnt != 4'd0) cnt <= cnt - 4'd1;
        T_BUSY:   cnt <= cnt;
        default:  cnt <= 4'd0;
      endcase
      if (arb_en) begin
        if (win_found) begin
          hgrant <= ONE << win_idx;
          rr     <= win_idx;
        end else begin
          hgrant <= DEF_GRANT;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed bench for ahb_master_arbiter
// Linear directed steps; outputs sampled 1 time unit after each rising edge.
module tb_ahb_master_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

  logic       hclk = 1'b0;
  logic       hresetn = 1'b1;
  logic [2:0] hbusreq = '0;
  logic [2:0] hlock = '0;
  logic [1:0] htrans = IDLE;
  logic [2:0] hburst = SINGLE;
  logic       hready = 1'b1;
  logic [2:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       hmastlock;

  int n_asserts = 0;
  int n_fail = 0;

  ahb_master_arbiter #(.MST_NUM(3), .DEF_MASTER(0)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hgrant(hgrant),
    .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
    chk("grant_onehot", 32'($onehot(hgrant)), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hgrant"}, 32'(hgrant), 32'b001);
    chk({tag, "_hmaster"}, 32'(hmaster), 32'd0);
    chk({tag, "_hmaster_data"}, 32'(hmaster_data), 32'd0);
    chk({tag, "_hmastlock"}, 32'(hmastlock), 32'd0);
  endtask

  task automatic do_reset();
    hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;
    hresetn = 1'b0;
    #1;
    chk_reset_vals("rst_pulse");
    hresetn = 1'b1;
  endtask

  // Master 1 runs INCR4 with master 2 waiting; optional BUSY after beat 2, optional stall at beat 3
  task automatic run_incr4(input string tag, input int stall);
    do_reset();
    hbusreq = 3'b010;
    tick(); chk({tag, "_grant_m1"}, 32'(hgrant), 32'b010);
    tick(); chk({tag, "_hmaster_m1"}, 32'(hmaster), 32'd1);
    chk({tag, "_grant_kept"}, 32'(hgrant), 32'b010);
    hbusreq = 3'b110; htrans = NONSEQ; hburst = INCR4;
    tick(); chk({tag, "_b1"}, 32'(hgrant), 32'b010);
    chk({tag, "_cnt_b1"}, 32'(dut.cnt), 32'd3);
    htrans = SEQ;
    tick(); chk({tag, "_b2"}, 32'(hgrant), 32'b010);
    if (stall == 0) begin
      htrans = BUSY;
      tick(); chk({tag, "_busy"}, 32'(hgrant), 32'b010);
      chk({tag, "_cnt_busy"}, 32'(dut.cnt), 32'd2);
    end
    htrans = SEQ;
    if (stall != 0) begin
      hready = 1'b0;
      hbusreq = 3'b100;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk({tag, "_stall_grant"}, 32'(hgrant), 32'b010);
        chk({tag, "_stall_hmaster"}, 32'(hmaster), 32'd1);
        chk({tag, "_stall_cnt"}, 32'(dut.cnt), 32'd2);
      end
      hready = 1'b1;
      hbusreq = 3'b110;
    end
    tick(); chk({tag, "_b3"}, 32'(hgrant), 32'b010);
    chk({tag, "_cnt_b3"}, 32'(dut.cnt), 32'd1);
    tick(); chk({tag, "_b4_handover"}, 32'(hgrant), 32'b100);
    chk({tag, "_b4_hmaster"}, 32'(hmaster), 32'd1);
    htrans = IDLE; hbusreq = 3'b100;
    tick(); chk({tag, "_m2_addr"}, 32'(hmaster), 32'd2);
  endtask

  initial begin
    logic [2:0] rr_seq [6];
    rr_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    // reset state, held with no requests
    #1 hresetn = 1'b0;
    #1 chk_reset_vals("rst_async");
    tick(); chk_reset_vals("rst_held");
    hresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk_reset_vals("idle");
    end

    // single requester: grant, address owner, data owner each one edge apart
    hbusreq = 3'b100; htrans = NONSEQ; hburst = SINGLE;
    tick(); chk("m2_grant_e1", 32'(hgrant), 32'b100); chk("m2_hmaster_e1", 32'(hmaster), 32'd0);
    tick(); chk("m2_hmaster_e2", 32'(hmaster), 32'd2); chk("m2_data_e2", 32'(hmaster_data), 32'd0);
    tick(); chk("m2_data_e3", 32'(hmaster_data), 32'd2); chk("m2_grant_e3", 32'(hgrant), 32'b100);

    // all three request SINGLE transfers: strict rotation
    do_reset();
    hbusreq = 3'b111; htrans = NONSEQ; hburst = SINGLE;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("rr_order", 32'(hgrant), 32'(rr_seq[i]));
    end

    run_incr4("incr4_busy", 0);
    run_incr4("incr4_stall", 1);

    // locked master 0 across two INCR4 bursts while master 1 waits
    do_reset();
    hbusreq = 3'b011; hlock = 3'b001;
    tick(); chk("lk_grant_e1", 32'(hgrant), 32'b001); chk("lk_mastlock_e1", 32'(hmastlock), 32'd1);
    for (int b = 0; b < 2; b++) begin
      htrans = NONSEQ; hburst = INCR4;
      tick(); chk("lk_grant_nseq", 32'(hgrant), 32'b001); chk("lk_mastlock", 32'(hmastlock), 32'd1);
      htrans = SEQ;
      for (int s = 0; s < 3; s++) begin
        if (b == 1 && s == 2) hlock = 3'b000;
        tick();
        if (b == 1 && s == 2) begin
          chk("lk_release_grant", 32'(hgrant), 32'b010);
          chk("lk_release_mastlock", 32'(hmastlock), 32'd0);
        end else begin
          chk("lk_grant_seq", 32'(hgrant), 32'b001);
          chk("lk_mastlock_seq", 32'(hmastlock), 32'd1);
        end
      end
    end

    // asynchronous reset during INCR8 beat 2 by master 2
    do_reset();
    hbusreq = 3'b100;
    tick(); chk("r8_grant", 32'(hgrant), 32'b100);
    tick(); chk("r8_hmaster", 32'(hmaster), 32'd2);
    htrans = NONSEQ; hburst = INCR8;
    tick(); chk("r8_cnt_b1", 32'(dut.cnt), 32'd7);
    htrans = SEQ;
    #2 hresetn = 1'b0;
    #1 chk_reset_vals("r8_async");
    chk("r8_cnt_cleared", 32'(dut.cnt), 32'd0);
    hresetn = 1'b1;
    htrans = IDLE; hburst = SINGLE; hbusreq = 3'b110;
    tick(); chk("r8_post_grant", 32'(hgrant), 32'b010);
    tick(); chk("r8_post_hmaster", 32'(hmaster), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
